dw_prod_accum: RTL and testbench

Sequential signed accumulator that sits directly downstream of the two's-complement multiplier. It consumes a frame of `len` signed products over a valid/ready handshake and sums them with per-step saturation. It presents one accumulated result per frame on an output valid/ready port, held until the consumer takes it. Typical uses are dot products and FIR taps built from the combinational multiplier.

---
 rtl/dw_accum_pkg.sv | 19 +
 rtl/dw_sat_add.sv | 34 +++
 rtl/dw_prod_accum.sv | 80 ++++++++
 tb/tb_dw_prod_accum.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/dw_accum_pkg.sv
// Shared types and helpers for the product accumulator datapath.
package dw_accum_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_t;

  // Two's-complement bounds for a given width, returned in the low 'width' bits.
  function automatic logic [63:0] signed_max(input int width);
    return (64'd1 << (width - 1)) - 64'd1;
  endfunction

  function automatic logic [63:0] signed_min(input int width);
    return ~signed_max(width);
  endfunction

endpackage

// File: rtl/dw_sat_add.sv
// Combinational signed adder: acc + sign-extended product, clamped to acc_width.
module dw_sat_add
  import dw_accum_pkg::*;
#(
  parameter int prod_width = 16,
  parameter int acc_width  = 24
) (
  input  logic signed [acc_width-1:0]  a,
  input  logic signed [prod_width-1:0] b,
  output logic signed [acc_width-1:0]  sum,
  output logic                         ovf
);

  localparam logic [acc_width-1:0] max_val = acc_width'(signed_max(acc_width));
  localparam logic [acc_width-1:0] min_val = acc_width'(signed_min(acc_width));

  logic signed [acc_width:0] wide;

  assign wide = {a[acc_width-1], a}
              + {{(acc_width + 1 - prod_width){b[prod_width-1]}}, b};

  // The extra sign bit disagreeing with the acc_width sign bit means the
  // true sum left the representable range; its true sign picks the bound.
  always_comb begin
    // NOTE: defaults first so every path assigns every output; no latch.
    sum = wide[acc_width-1:0];
    ovf = 1'b0;
    if (wide[acc_width] != wide[acc_width-1]) begin
      sum = wide[acc_width] ? min_val : max_val;
      ovf = 1'b1;
    end
  end

endmodule

// File: rtl/dw_prod_accum.sv
// Frame accumulator for signed products: valid/ready in, one saturated sum per frame out.
module dw_prod_accum
  import dw_accum_pkg::*;
#(
  parameter int prod_width = 16,
  parameter int acc_width  = 24,
  parameter int len_width  = 8
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         start,
  input  logic [len_width-1:0]         len,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic signed [prod_width-1:0] product,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic signed [acc_width-1:0]  acc_out,
  output logic                         ovf,
  output logic                         busy
);

  state_t                       state;
  logic [len_width-1:0]         cnt;
  logic signed [acc_width-1:0]  acc;
  logic                         ovf_q;
  logic signed [acc_width-1:0]  sum;
  logic                         step_ovf;

  dw_sat_add #(
    .prod_width(prod_width),
    .acc_width (acc_width)
  ) u_sat_add (
    .a  (acc),
    .b  (product),
    .sum(sum),
    .ovf(step_ovf)
  );

  // Outputs come from registers or state decode only.
  assign in_ready  = (state == ACCUM);
  assign out_valid = (state == DONE);
  assign busy      = (state != IDLE);
  assign acc_out   = acc;
  assign ovf       = ovf_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: state uses non-blocking assignments so every flop samples pre-edge values.
      state <= IDLE;
      cnt   <= '0;
      acc   <= '0;
      ovf_q <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            acc   <= '0;
            ovf_q <= 1'b0;
            cnt   <= len;
            state <= (len != '0) ? ACCUM : DONE;
          end
        end
        ACCUM: begin
          if (in_valid) begin
            acc   <= sum;
            ovf_q <= ovf_q | step_ovf;
            cnt   <= cnt - 1'b1;
            if (cnt == len_width'(1)) state <= DONE;
          end
        end
        DONE: begin
          if (out_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dw_prod_accum.sv
// Randomized scoreboard bench for dw_prod_accum against an integer reference model.
module tb_dw_prod_accum;

  localparam int PW = 16;
  localparam int AW = 16;
  localparam int LW = 8;
  localparam longint MAXV = (64'sd1 <<< (AW - 1)) - 1;
  localparam longint MINV = -(64'sd1 <<< (AW - 1));

  typedef struct {
    longint acc;
    bit     ovf;
  } exp_t;

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic                 start;
  logic [LW-1:0]        len;
  logic                 in_valid;
  logic                 in_ready;
  logic signed [PW-1:0] product;
  logic                 out_valid;
  logic                 out_ready;
  logic signed [AW-1:0] acc_out;
  logic                 ovf;
  logic                 busy;

  int   n_checks = 0;
  int   n_errors = 0;
  exp_t exp_q[$];
  int   prod_q[$];

  dw_prod_accum #(
    .prod_width(PW),
    .acc_width (AW),
    .len_width (LW)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .len      (len),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .product  (product),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .acc_out  (acc_out),
    .ovf      (ovf),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input longint act, input longint req);
    n_checks++;
    if (act !== req) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, req, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor: compares the presented result on the cycle it is taken.
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n && out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_result", 1, 0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check("acc_out", longint'(acc_out), e.acc);
          check("ovf", ovf, e.ovf);
        end
      end
    end
  end

  function automatic int rand_prod(input bit big);
    logic signed [PW-1:0] r;
    if (big) r = $urandom_range(1) ? PW'(16'h7FFF - $urandom_range(255))
                                   : PW'(16'h8000 + $urandom_range(255));
    else     r = PW'($urandom);
    return int'(r);
  endfunction

  // Runs one frame using the first n entries of prod_q.
  task automatic do_frame(input int n, input int valid_pct, input int hold);
    longint a = 0;
    bit     o = 1'b0;
    int     i = 0;
    int     budget = 0;
    logic signed [AW-1:0] held;
    for (int k = 0; k < n; k++) begin
      a = a + prod_q[k];
      if (a > MAXV) begin a = MAXV; o = 1'b1; end
      else if (a < MINV) begin a = MINV; o = 1'b1; end
    end
    exp_q.push_back('{acc: a, ovf: o});

    start    = 1'b1;
    len      = LW'(n);
    in_valid = (n == 0);
    product  = 16'sh1234;
    tick();
    start = 1'b0;
    check("in_ready_after_start", in_ready, n != 0);
    check("out_valid_after_start", out_valid, n == 0);
    if (n == 0) check("zero_len_no_consume", in_ready, 0);

    while (i < n && budget < 4000) begin
      bit took;
      in_valid = ($urandom_range(99) < valid_pct);
      product  = PW'(prod_q[i]);
      took     = in_valid && in_ready;
      tick();
      if (took) i++;
      else check("no_early_done", out_valid, 0);
      budget++;
    end
    if (i < n) check("frame_timeout", i, n);
    in_valid = 1'b0;
    check("out_valid_latency", out_valid, 1);

    held = acc_out;
    for (int h = 0; h < hold; h++) begin
      start = $urandom_range(1);
      len   = 8'd3;
      tick();
      check("hold_acc_stable", longint'(acc_out), longint'(held));
      check("hold_out_valid", out_valid, 1);
      check("hold_in_ready", in_ready, 0);
    end
    start     = 1'b0;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("idle_after_take", busy, 0);
    check("out_valid_cleared", out_valid, 0);
  endtask

  initial begin
    rst_n     = 1'b0;
    start     = 1'b0;
    len       = '0;
    in_valid  = 1'b0;
    product   = '0;
    out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready", in_ready, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_acc_out", longint'(acc_out), 0);
    check("rst_ovf", ovf, 0);
    check("rst_busy", busy, 0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    prod_q = '{3, -5, 100, -1};
    do_frame(4, 100, 0);
    prod_q = '{32767, 32767, 32767};
    do_frame(3, 100, 0);
    prod_q = '{-32768, -32768, -32768};
    do_frame(3, 100, 0);
    prod_q = '{32767, -10};
    do_frame(2, 100, 0);
    prod_q = '{};
    do_frame(0, 100, 0);

    prod_q.delete();
    for (int k = 0; k < 5; k++) prod_q.push_back(rand_prod(1'b0));
    do_frame(5, 50, 10);

    // Reset after two of four products: partial sum must vanish.
    start = 1'b1;
    len   = 8'd4;
    tick();
    start    = 1'b0;
    in_valid = 1'b1;
    product  = 16'sd1000;
    tick();
    product = 16'sd2000;
    tick();
    in_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_in_ready", in_ready, 0);
    check("midrst_out_valid", out_valid, 0);
    check("midrst_acc_out", longint'(acc_out), 0);
    check("midrst_ovf", ovf, 0);
    check("midrst_busy", busy, 0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    prod_q = '{7, -2, 11, 4};
    do_frame(4, 100, 0);

    for (int f = 0; f < 25; f++) begin
      int n;
      bit big;
      n   = $urandom_range(1, 12);
      big = ($urandom_range(2) == 0);
      prod_q.delete();
      for (int k = 0; k < n; k++) prod_q.push_back(rand_prod(big));
      do_frame(n, $urandom_range(60, 100), $urandom_range(0, 3));
    end

    prod_q.delete();
    for (int k = 0; k < 255; k++) prod_q.push_back(rand_prod(1'b0));
    do_frame(255, 90, 1);

    repeat (3) tick();
    check("scoreboard_drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
